// File: rtl/oam_dma_ctrl_pkg.sv
// Shared CPU-side definitions for the sprite DMA sequencer: register addresses,
// transfer length and the sequencer state encoding.
package oam_dma_ctrl_pkg;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam int          XFER_LEN      = 256;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_READ  = 3'd3,
        DMA_WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: owns the CPU bus, stalls the core and copies one page
// to OAMDATA as alternating get/put cycles; transparent when idle.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clock_en,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_r_en,
    input  logic [7:0]  cpu_w_data,
    input  logic [7:0]  mem_r_data,
    output logic [15:0] mem_addr,
    output logic        mem_r_en,
    output logic [7:0]  mem_w_data,
    output logic        cpu_stall,
    output logic        dma_active
);

    localparam int IDX_W = $clog2(XFER_LEN);

    dma_state_t       state;
    logic [7:0]       page;
    logic [IDX_W-1:0] idx;
    logic             put_cycle;
    logic             trigger;

    assign trigger = (state == DMA_IDLE) && (cpu_addr == DMA_REG_ADDR) && !cpu_r_en;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= DMA_IDLE;
            page      <= '0;
            idx       <= '0;
            put_cycle <= 1'b0;
        end else if (clock_en) begin
            // Parity runs freely so HALT knows whether the next cycle is a get.
            put_cycle <= ~put_cycle;
            case (state)
                DMA_IDLE: begin
                    if (trigger) begin
                        page  <= cpu_w_data;
                        idx   <= '0;
                        state <= DMA_HALT;
                    end
                end
                DMA_HALT:  state <= put_cycle ? DMA_READ : DMA_ALIGN;
                DMA_ALIGN: state <= DMA_READ;
                DMA_READ:  state <= DMA_WRITE;
                DMA_WRITE: begin
                    if (idx == IDX_W'(XFER_LEN - 1)) begin
                        idx   <= '0;
                        state <= DMA_IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= DMA_READ;
                    end
                end
                default: state <= DMA_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr   = cpu_addr;
        mem_r_en   = cpu_r_en;
        mem_w_data = cpu_w_data;
        case (state)
            DMA_HALT, DMA_ALIGN: begin
                mem_r_en   = 1'b1;
                mem_w_data = '0;
            end
            DMA_READ: begin
                // idx never carries into page: page $FF stays within $FF00..$FFFF.
                mem_addr   = {page, 8'(idx)};
                mem_r_en   = 1'b1;
                mem_w_data = '0;
            end
            DMA_WRITE: begin
                mem_addr   = OAM_DATA_ADDR;
                mem_r_en   = 1'b0;
                mem_w_data = mem_r_data;
            end
            default: ;
        endcase
    end

    assign cpu_stall  = (state != DMA_IDLE);
    assign dma_active = cpu_stall;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for the sprite DMA sequencer with a registered-read memory model.
module tb_oam_dma_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clock_en = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_r_en = 1'b1;
    logic [7:0]  cpu_w_data = 8'h00;
    logic [7:0]  mem_r_data = 8'h00;
    logic [15:0] mem_addr;
    logic        mem_r_en;
    logic [7:0]  mem_w_data;
    logic        cpu_stall;
    logic        dma_active;

    int tests = 0;
    int fails = 0;

    logic [7:0]  ram [0:65535];
    logic [7:0]  wlog [0:2047];
    logic [15:0] rlog [0:2047];
    int          wcnt = 0;
    int          rcnt = 0;
    logic        tb_par;

    oam_dma_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clock_en   (clock_en),
        .cpu_addr   (cpu_addr),
        .cpu_r_en   (cpu_r_en),
        .cpu_w_data (cpu_w_data),
        .mem_r_data (mem_r_data),
        .mem_addr   (mem_addr),
        .mem_r_en   (mem_r_en),
        .mem_w_data (mem_w_data),
        .cpu_stall  (cpu_stall),
        .dma_active (dma_active)
    );

    always #5 clock = ~clock;

    // cpu_memory model: registered read data, logs $2004 writes and DMA source reads
    always @(posedge clock) begin
        if (clock_en) begin
            if (mem_r_en) mem_r_data <= ram[mem_addr];
            if (!mem_r_en && mem_addr == 16'h2004 && wcnt < 2048) begin
                wlog[wcnt] <= mem_w_data;
                wcnt <= wcnt + 1;
            end
            if (mem_r_en && dma_active && mem_addr != 16'h4014 && rcnt < 2048) begin
                rlog[rcnt] <= mem_addr;
                rcnt <= rcnt + 1;
            end
        end
    end

    // expected get/put parity, tracked independently of the DUT
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) tb_par <= 1'b0;
        else if (clock_en) tb_par <= ~tb_par;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    // Called at a negedge. Triggers a DMA from pg, returns stalled-cycle count.
    task automatic run_dma(input logic [7:0] pg, input bit halt_put, input bit no_wait,
                           input bit gate, output int stall, output bit tmo);
        if (!no_wait && tb_par == halt_put) @(negedge clock);
        cpu_addr = 16'h4014; cpu_r_en = 1'b0; cpu_w_data = pg;
        @(negedge clock);
        cpu_r_en = 1'b1; cpu_w_data = 8'h00;
        stall = 0; tmo = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (!cpu_stall) begin tmo = 1'b0; break; end
            stall++;
            if (gate) clock_en = ~clock_en;
            @(negedge clock);
        end
        clock_en = 1'b1;
    endtask

    task automatic test_reset;
        cpu_addr = 16'h1234; cpu_r_en = 1'b0; cpu_w_data = 8'hAA;
        #1;
        tests++;
        if (cpu_stall !== 1'b0 || dma_active !== 1'b0) begin
            fails++; $display("FAIL reset_stall: got %b/%b want 0/0", cpu_stall, dma_active);
        end
        tests++;
        if (mem_addr !== 16'h1234 || mem_r_en !== 1'b0 || mem_w_data !== 8'hAA) begin
            fails++; $display("FAIL reset_passthru: got %h/%b/%h want 1234/0/aa", mem_addr, mem_r_en, mem_w_data);
        end
        cpu_addr = 16'h0000; cpu_r_en = 1'b1; cpu_w_data = 8'h00;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_passthrough;
        cpu_addr = 16'h0123; cpu_r_en = 1'b1; cpu_w_data = 8'h00;
        #1;
        tests++;
        if (mem_addr !== 16'h0123 || mem_r_en !== 1'b1 || cpu_stall !== 1'b0) begin
            fails++; $display("FAIL idle_read: got %h/%b/%b want 0123/1/0", mem_addr, mem_r_en, cpu_stall);
        end
        @(negedge clock);
        cpu_addr = 16'h0456; cpu_r_en = 1'b0; cpu_w_data = 8'h55;
        #1;
        tests++;
        if (mem_addr !== 16'h0456 || mem_r_en !== 1'b0 || mem_w_data !== 8'h55 || cpu_stall !== 1'b0) begin
            fails++; $display("FAIL idle_write: got %h/%b/%h/%b want 0456/0/55/0", mem_addr, mem_r_en, mem_w_data, cpu_stall);
        end
        @(negedge clock);
        tests++;
        if (cpu_stall !== 1'b0) begin
            fails++; $display("FAIL idle_nostall: got %b want 0", cpu_stall);
        end
        cpu_addr = 16'h0000; cpu_r_en = 1'b1; cpu_w_data = 8'h00;
    endtask

    task automatic test_dma_page2(input bit halt_put, input int exp_stall);
        int wb, rb, st, bad;
        bit tmo;
        wb = wcnt; rb = rcnt;
        run_dma(8'h02, halt_put, 1'b0, 1'b0, st, tmo);
        tests++;
        if (tmo || st != exp_stall) begin
            fails++; $display("FAIL stall_len_%0d: got %0d (timeout %b) want %0d", halt_put, st, tmo, exp_stall);
        end
        tests++;
        if (wcnt - wb != 256 || rcnt - rb != 256) begin
            fails++; $display("FAIL xfer_count_%0d: got w%0d r%0d want 256", halt_put, wcnt - wb, rcnt - rb);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (wlog[wb + i] !== (8'(i) ^ 8'hA5)) bad++;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL xfer_data_%0d: got %0d wrong bytes want 0", halt_put, bad);
        end
    endtask

    task automatic test_clock_en_gating;
        int wb, rb, st, bad;
        bit tmo;
        wb = wcnt; rb = rcnt;
        run_dma(8'h07, 1'b1, 1'b0, 1'b1, st, tmo);
        tests++;
        if (tmo || wcnt - wb != 256) begin
            fails++; $display("FAIL gate_count: got %0d writes (timeout %b) want 256", wcnt - wb, tmo);
        end
        tests++;
        if (rlog[rb] !== 16'h0700 || rlog[rb + 255] !== 16'h07FF) begin
            fails++; $display("FAIL gate_addr: got %h..%h want 0700..07ff", rlog[rb], rlog[rb + 255]);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (wlog[wb + i] !== (8'(i) + 8'h3C)) bad++;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL gate_data: got %0d wrong bytes want 0", bad);
        end
    endtask

    task automatic test_reset_mid_dma;
        int wb;
        wb = wcnt;
        cpu_addr = 16'h4014; cpu_r_en = 1'b0; cpu_w_data = 8'h02;
        @(negedge clock);
        cpu_r_en = 1'b1; cpu_w_data = 8'h00;
        for (int k = 0; k < 1000 && (wcnt - wb) < 100; k++) @(negedge clock);
        reset_n = 1'b0;
        #1;
        tests++;
        if (cpu_stall !== 1'b0 || dma_active !== 1'b0 || mem_addr !== 16'h4014 || mem_r_en !== 1'b1) begin
            fails++; $display("FAIL midreset_idle: got %b/%b/%h/%b want 0/0/4014/1", cpu_stall, dma_active, mem_addr, mem_r_en);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (600) @(negedge clock);
        tests++;
        if (wcnt - wb != 100 || cpu_stall !== 1'b0) begin
            fails++; $display("FAIL midreset_writes: got %0d writes stall %b want 100/0", wcnt - wb, cpu_stall);
        end
    endtask

    task automatic test_back_to_back;
        int wb, rb, st, bad, zero_rd;
        bit tmo;
        wb = wcnt; rb = rcnt;
        // unaligned from $FF leaves an odd edge count, so the next DMA is aligned
        run_dma(8'hFF, 1'b0, 1'b0, 1'b0, st, tmo);
        tests++;
        if (tmo || st != 514 || wcnt - wb != 256) begin
            fails++; $display("FAIL wrap_len: got stall %0d writes %0d want 514/256", st, wcnt - wb);
        end
        zero_rd = 0;
        for (int i = 0; i < 256; i++) if (rlog[rb + i][15:8] !== 8'hFF) zero_rd++;
        tests++;
        if (rlog[rb + 255] !== 16'hFFFF || zero_rd != 0) begin
            fails++; $display("FAIL wrap_addr: got last %h off-page %0d want ffff/0", rlog[rb + 255], zero_rd);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (wlog[wb + i] !== ~8'(i)) bad++;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL wrap_data: got %0d wrong bytes want 0", bad);
        end
        wb = wcnt;
        run_dma(8'h02, 1'b1, 1'b1, 1'b0, st, tmo);
        tests++;
        if (tmo || st != 513 || wcnt - wb != 256) begin
            fails++; $display("FAIL b2b_len: got stall %0d writes %0d want 513/256", st, wcnt - wb);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (wlog[wb + i] !== (8'(i) ^ 8'hA5)) bad++;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL b2b_data: got %0d wrong bytes want 0", bad);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'hEE;
        for (int i = 0; i < 256; i++) begin
            ram[16'h0200 + i] = 8'(i) ^ 8'hA5;
            ram[16'h0700 + i] = 8'(i) + 8'h3C;
            ram[16'hFF00 + i] = ~8'(i);
        end
        test_reset;
        test_passthrough;
        test_dma_page2(1'b1, 513);
        test_dma_page2(1'b0, 514);
        test_clock_en_gating;
        test_reset_mid_dma;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
